// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: datapath widths, tag map and reservation-station entry layout.
package tomasulo_pkg;

  localparam int DATA_W       = 8;
  localparam int TAG_W        = 3;
  localparam logic [TAG_W-1:0] TAG_NONE = '0;
  localparam int ADD_TAG_BASE = 1;
  localparam int MUL_TAG_BASE = 4;

  typedef struct packed {
    logic              busy;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for a reservation station: tracks allocation order and grants the oldest ready slot.
module rs_age_matrix #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] alloc_i,
  input  logic [N-1:0] free_i,
  input  logic [N-1:0] ready_i,
  output logic [N-1:0] grant_o
);

  // older_q[i][j] = 1 means slot j was allocated before slot i
  logic [N-1:0][N-1:0] older_q, older_d;

  always_comb begin
    older_d = older_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (free_i[i] || free_i[j] || i == j) begin
          older_d[i][j] = 1'b0;
        end else if (alloc_i[i]) begin
          older_d[i][j] = 1'b1;
        end else if (alloc_i[j]) begin
          older_d[i][j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      older_q <= '0;
    end else begin
      older_q <= older_d;
    end
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      grant_o[i] = ready_i[i] && ((older_q[i] & ready_i) == '0);
    end
  end

endmodule

// File: rtl/add_rs_scheduler.sv
// Adder reservation station: allocates slots, snoops the CDB and dispatches the oldest ready op
// to the single shared adder, one operation in flight at a time.
module add_rs_scheduler #(
  parameter int NUM_ENTRIES = 3,
  parameter int DATA_W      = tomasulo_pkg::DATA_W,
  parameter int TAG_W       = tomasulo_pkg::TAG_W,
  parameter int TAG_BASE    = tomasulo_pkg::ADD_TAG_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [TAG_W-1:0]       issue_qj,
  input  logic [DATA_W-1:0]      issue_vj,
  input  logic [TAG_W-1:0]       issue_qk,
  input  logic [DATA_W-1:0]      issue_vk,
  output logic [TAG_W-1:0]       issue_tag,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [DATA_W-1:0]      cdb_data,
  output logic                   add_start,
  output logic [TAG_W-1:0]       add_tag,
  output logic [DATA_W-1:0]      add_src1,
  output logic [DATA_W-1:0]      add_src2,
  input  logic                   add_done,
  output logic [NUM_ENTRIES-1:0] rs_busy
);

  import tomasulo_pkg::rs_entry_t;
  import tomasulo_pkg::TAG_NONE;

  rs_entry_t slot_q [NUM_ENTRIES];
  rs_entry_t slot_d [NUM_ENTRIES];
  rs_entry_t sel;

  logic [NUM_ENTRIES-1:0] busy, ready, alloc_oh, grant, age_alloc, age_free;
  logic [TAG_W-1:0]       alloc_idx, sel_tag;
  logic                   do_issue, dispatch;
  logic                   in_flight_q, in_flight_d;
  logic                   add_start_q;
  logic [TAG_W-1:0]       add_tag_q;
  logic [DATA_W-1:0]      add_src1_q, add_src2_q;

  always_comb begin
    busy  = '0;
    ready = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      busy[i]  = slot_q[i].busy;
      ready[i] = slot_q[i].busy && slot_q[i].qj == TAG_NONE && slot_q[i].qk == TAG_NONE;
    end
  end

  always_comb begin
    alloc_oh  = '0;
    alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
        alloc_idx   = TAG_W'(i);
      end
    end
  end

  assign issue_ready = (|(~busy)) && !flush;
  assign issue_tag   = TAG_W'(TAG_BASE) + alloc_idx;
  assign do_issue    = issue_valid && issue_ready;
  // add_done frees the adder in time for a same-cycle dispatch
  assign dispatch    = (!in_flight_q || add_done) && (|ready) && !flush;
  assign age_alloc   = do_issue ? alloc_oh : '0;
  assign age_free    = flush ? '1 : (dispatch ? grant : '0);

  rs_age_matrix #(.N(NUM_ENTRIES)) u_age (
    .clk     (clk),
    .rst     (rst),
    .alloc_i (age_alloc),
    .free_i  (age_free),
    .ready_i (ready),
    .grant_o (grant)
  );

  always_comb begin
    sel     = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (grant[i]) begin
        sel     = slot_q[i];
        sel_tag = TAG_W'(TAG_BASE + i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      slot_d[i] = slot_q[i];
      if (slot_q[i].busy && cdb_valid) begin
        if (slot_q[i].qj != TAG_NONE && slot_q[i].qj == cdb_tag) begin
          slot_d[i].qj = TAG_NONE;
          slot_d[i].vj = cdb_data;
        end
        if (slot_q[i].qk != TAG_NONE && slot_q[i].qk == cdb_tag) begin
          slot_d[i].qk = TAG_NONE;
          slot_d[i].vk = cdb_data;
        end
      end
      if (dispatch && grant[i]) begin
        slot_d[i] = '0;
      end
      if (do_issue && alloc_oh[i]) begin
        slot_d[i].busy = 1'b1;
        slot_d[i].qj   = issue_qj;
        slot_d[i].vj   = issue_vj;
        slot_d[i].qk   = issue_qk;
        slot_d[i].vk   = issue_vk;
        if (cdb_valid && issue_qj != TAG_NONE && issue_qj == cdb_tag) begin
          slot_d[i].qj = TAG_NONE;
          slot_d[i].vj = cdb_data;
        end
        if (cdb_valid && issue_qk != TAG_NONE && issue_qk == cdb_tag) begin
          slot_d[i].qk = TAG_NONE;
          slot_d[i].vk = cdb_data;
        end
      end
      if (flush) begin
        slot_d[i] = '0;
      end
    end
  end

  always_comb begin
    in_flight_d = in_flight_q;
    if (flush) begin
      in_flight_d = 1'b0;
    end else if (dispatch) begin
      in_flight_d = 1'b1;
    end else if (add_done) begin
      in_flight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        slot_q[i] <= '0;
      end
      in_flight_q <= 1'b0;
      add_start_q <= 1'b0;
      add_tag_q   <= '0;
      add_src1_q  <= '0;
      add_src2_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        slot_q[i] <= slot_d[i];
      end
      in_flight_q <= in_flight_d;
      add_start_q <= dispatch;
      if (dispatch) begin
        add_tag_q  <= sel_tag;
        add_src1_q <= sel.vj;
        add_src2_q <= sel.vk;
      end
    end
  end

  assign add_start = add_start_q;
  assign add_tag   = add_tag_q;
  assign add_src1  = add_src1_q;
  assign add_src2  = add_src2_q;
  assign rs_busy   = busy;

endmodule

// File: tb/tb_add_rs_scheduler.sv
// Scoreboard bench for add_rs_scheduler: directed issue/CDB/done sequences, monitor checks every dispatch.
module tb_add_rs_scheduler;

  logic       clk = 1'b0;
  logic       rst, flush, issue_valid, issue_ready;
  logic [2:0] issue_qj, issue_qk, issue_tag, cdb_tag, add_tag;
  logic [7:0] issue_vj, issue_vk, cdb_data, add_src1, add_src2;
  logic       cdb_valid, add_start, add_done;
  logic [2:0] rs_busy;

  add_rs_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_qj(issue_qj), .issue_vj(issue_vj), .issue_qk(issue_qk), .issue_vk(issue_vk),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .add_start(add_start), .add_tag(add_tag), .add_src1(add_src1), .add_src2(add_src2),
    .add_done(add_done), .rs_busy(rs_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] tag;
    logic [7:0] s1;
    logic [7:0] s2;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every dispatch strobe must match the next expected operation in order
  always @(negedge clk) begin
    if (!rst && add_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_start: tag %0h src1 %0h src2 %0h with nothing expected",
                 add_tag, add_src1, add_src2);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("start_tag", add_tag, e.tag);
        check("start_src1", add_src1, e.s1);
        check("start_src2", add_src2, e.s2);
      end
    end
  end

  task automatic push_exp(input logic [2:0] t, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.tag = t; e.s1 = a; e.s2 = b;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] qj, input logic [7:0] vj, input logic [2:0] qk,
                       input logic [7:0] vk, input logic [2:0] exp_tag,
                       input logic cv, input logic [2:0] ct, input logic [7:0] cd);
    @(negedge clk);
    issue_valid = 1'b1;
    issue_qj = qj; issue_vj = vj; issue_qk = qk; issue_vk = vk;
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
    #1;
    check("issue_ready", issue_ready, 1);
    check("issue_tag", issue_tag, exp_tag);
    @(negedge clk);
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    add_done = 1'b1;
    @(negedge clk);
    add_done = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d dispatches outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0;
    issue_qj = '0; issue_vj = '0; issue_qk = '0; issue_vk = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; add_done = 1'b0;
    #12;
    check("rst_add_start", add_start, 0);
    check("rst_add_tag", add_tag, 0);
    check("rst_add_src1", add_src1, 0);
    check("rst_add_src2", add_src2, 0);
    check("rst_rs_busy", rs_busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Both operands ready at issue
    push_exp(3'd1, 8'h05, 8'h03);
    issue(3'd0, 8'h05, 3'd0, 8'h03, 3'd1, 1'b0, 3'd0, 8'h00);
    drain();
    check("t1_busy_after", rs_busy, 0);
    pulse_done();

    // Operand 1 waits for MUL tag 4
    issue(3'd4, 8'h00, 3'd0, 8'h10, 3'd1, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    check("t2_no_start_pending", add_start, 0);
    check("t2_busy_pending", rs_busy, 3'b001);
    push_exp(3'd1, 8'h22, 8'h10);
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 8'h22;
    @(negedge clk);
    cdb_valid = 1'b0;
    drain();
    pulse_done();

    // Same-cycle CDB bypass at issue
    push_exp(3'd1, 8'h7F, 8'h01);
    issue(3'd4, 8'h00, 3'd0, 8'h01, 3'd1, 1'b1, 3'd4, 8'h7F);
    drain();
    pulse_done();

    // Fill all slots while the adder is busy, then release in order
    push_exp(3'd1, 8'h11, 8'h22);
    issue(3'd0, 8'h11, 3'd0, 8'h22, 3'd1, 1'b0, 3'd0, 8'h00);
    drain();
    push_exp(3'd1, 8'hA1, 8'hB1);
    issue(3'd0, 8'hA1, 3'd0, 8'hB1, 3'd1, 1'b0, 3'd0, 8'h00);
    push_exp(3'd2, 8'hA2, 8'hB2);
    issue(3'd0, 8'hA2, 3'd0, 8'hB2, 3'd2, 1'b0, 3'd0, 8'h00);
    push_exp(3'd3, 8'hA3, 8'hB3);
    issue(3'd0, 8'hA3, 3'd0, 8'hB3, 3'd3, 1'b0, 3'd0, 8'h00);
    #1;
    check("t4_full_not_ready", issue_ready, 0);
    check("t4_full_busy", rs_busy, 3'b111);
    check("t4_held_start", add_start, 0);
    for (int k = 0; k < 3; k++) begin
      pulse_done();
      #1;
      check("t4_start_after_done", add_start, 1);
    end
    pulse_done();
    check("t4_busy_empty", rs_busy, 0);

    // Older unready slot must not block a younger ready one
    issue(3'd5, 8'h00, 3'd0, 8'h01, 3'd1, 1'b0, 3'd0, 8'h00);
    push_exp(3'd2, 8'h30, 8'h02);
    issue(3'd0, 8'h30, 3'd0, 8'h02, 3'd2, 1'b0, 3'd0, 8'h00);
    drain();
    check("t5_busy_slot0", rs_busy, 3'b001);
    @(negedge clk);
    push_exp(3'd1, 8'h40, 8'h01);
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 8'h40;
    @(negedge clk);
    cdb_valid = 1'b0;
    idle(2);
    check("t5_wait_in_flight", add_start, 0);
    pulse_done();
    #1;
    check("t5_start_after_done", add_start, 1);
    pulse_done();

    // Flush with busy slots, in-flight op and a concurrent issue
    push_exp(3'd1, 8'h01, 8'h02);
    issue(3'd0, 8'h01, 3'd0, 8'h02, 3'd1, 1'b0, 3'd0, 8'h00);
    drain();
    issue(3'd0, 8'h03, 3'd0, 8'h04, 3'd1, 1'b0, 3'd0, 8'h00);
    issue(3'd0, 8'h05, 3'd0, 8'h06, 3'd2, 1'b0, 3'd0, 8'h00);
    check("t6_busy_before_flush", rs_busy, 3'b011);
    @(negedge clk);
    flush = 1'b1; issue_valid = 1'b1; issue_qj = '0; issue_vj = 8'hEE; issue_qk = '0; issue_vk = 8'hEE;
    #1;
    check("t6_flush_not_ready", issue_ready, 0);
    @(negedge clk);
    flush = 1'b0; issue_valid = 1'b0;
    #1;
    check("t6_flush_busy", rs_busy, 0);
    check("t6_flush_no_start", add_start, 0);
    pulse_done();
    idle(3);
    push_exp(3'd1, 8'h0A, 8'h0B);
    issue(3'd0, 8'h0A, 3'd0, 8'h0B, 3'd1, 1'b0, 3'd0, 8'h00);
    drain();

    // Asynchronous reset in the middle of a dispatch
    issue(3'd0, 8'h0C, 3'd0, 8'h0D, 3'd1, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    add_done = 1'b1;
    @(posedge clk);
    #1;
    check("t7_start_before_rst", add_start, 1);
    add_done = 1'b0;
    rst = 1'b1;
    #1;
    check("t7_rst_start", add_start, 0);
    check("t7_rst_tag", add_tag, 0);
    check("t7_rst_src1", add_src1, 0);
    check("t7_rst_src2", add_src2, 0);
    check("t7_rst_busy", rs_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_done();
    idle(4);
    check("t7_idle_busy", rs_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/add_rs_scheduler.md
Name: add_rs_scheduler

Overview:
- Reservation-station controller and dispatch scheduler for the single shared 8-bit Adder_Unit in the Tomasulo core.
- Accepts ADD/SUB instructions from the issue stage into NUM_ENTRIES station slots.
- Snoops the common data bus (CDB) to capture pending operands.
- Dispatches the oldest fully-ready slot to the adder, one operation in flight at a time.

Parameters:
- NUM_ENTRIES, 3, number of reservation-station slots.
- DATA_W, 8, operand and result width.
- TAG_W, 3, tag width; tag 0 means "no producer, value valid".
- TAG_BASE, 1, tag of slot 0; slot i owns tag TAG_BASE+i.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  synchronous clear of all slots and the in-flight flag.
- issue_valid  input  1  issue stage presents an instruction.
- issue_ready  output  1  a free slot exists and flush=0.
- issue_qj  input  TAG_W  producer tag of operand 1 (0 = vj valid).
- issue_vj  input  DATA_W  operand 1 value.
- issue_qk  input  TAG_W  producer tag of operand 2 (0 = vk valid).
- issue_vk  input  DATA_W  operand 2 value.
- issue_tag  output  TAG_W  tag of the slot allocated on this handshake.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  TAG_W  CDB result tag.
- cdb_data  input  DATA_W  CDB result value.
- add_start  output  1  one-cycle dispatch strobe to the adder.
- add_tag  output  TAG_W  drives ADD_Tag_ip.
- add_src1  output  DATA_W  drives Source_Reg1.
- add_src2  output  DATA_W  drives Source_Reg2.
- add_done  input  1  adder completion pulse (ADD_Status rising).
- rs_busy  output  NUM_ENTRIES  per-slot occupied flags, for debug and stall logic.

Behaviour:
- Reset (async, rst=1) clears:
  - all slots: busy=0, qj=qk=0, vj=vk=0, age matrix cleared;
  - in_flight=0;
  - outputs: add_start=0, add_tag=0, add_src1=0, add_src2=0, rs_busy=0.
- Reset mid-operation discards every slot and the in-flight op. A later add_done while in_flight=0 is ignored.
- Allocation:
  - issue_ready is the combinational OR of ~busy, gated by ~flush.
  - On issue_valid & issue_ready, the lowest-index free slot is written at the edge.
  - issue_tag = TAG_BASE + that index (combinational, valid in the handshake cycle).
  - The new slot becomes the youngest in the age matrix.
- Same-cycle CDB bypass at issue: if cdb_valid and cdb_tag == issue_qj (with qj != 0), the slot stores vj=cdb_data and qj=0. Same rule for qk.
- Operand capture for occupied slots: each cycle with cdb_valid, every busy slot whose qj (or qk) equals cdb_tag latches cdb_data and clears that q field. A single broadcast may satisfy multiple slots and both operands of one slot.
- A slot is ready when busy, qj=0 and qk=0, as registered state.
  - Readiness from a CDB capture is visible the cycle after the capture.
- Dispatch:
  - Condition: in_flight=0, at least one ready slot, flush=0.
  - At the edge, the oldest ready slot is selected by the age matrix.
  - add_start, add_tag, add_src1 and add_src2 are registered: add_start is high exactly one cycle, and the other three hold until the next dispatch.
  - The dispatched slot's busy is cleared at the same edge. It is reusable for issue from the next cycle, and its age row/column is cleared.
  - in_flight is set at the same edge.
- Completion:
  - add_done with in_flight=1 clears in_flight at the edge.
  - A new dispatch may occur in the same cycle add_done is seen, so the earliest next add_start is the cycle after add_done.
  - The result itself travels on the CDB via the CDB arbiter, not through this block.
- Simultaneous events:
  - issue + dispatch in one cycle: both occur. The newly issued slot is never dispatched in its own issue cycle.
  - issue + CDB: bypass rule above applies.
  - flush with anything: flush wins. Issue is dropped, no dispatch, all slots cleared, in_flight=0. add_start is forced 0 the next cycle.
- Full: all slots busy, so issue_ready=0. This holds even if a dispatch frees a slot that cycle; the freed slot shows from the next cycle.
- Empty: no add_start; outputs hold their last values.

Decomposition:
- Shared package tomasulo_pkg holds:
  - DATA_W and TAG_W;
  - TAG_NONE = 0;
  - ADD_TAG_BASE = 1, MUL_TAG_BASE = 4;
  - the reservation-station entry typedef (busy, qj, qk, vj, vk).
- Sub-module rs_age_matrix (NUM_ENTRIES): inputs are alloc one-hot, free one-hot and ready vector; output is the oldest-ready one-hot grant. It is reusable by the multiplier station.

Test Plan:
- Reset then issue qj=0, vj=8'h05, qk=0, vk=8'h03 → issue_tag=1 in the handshake cycle; next cycle add_start=1, add_tag=1, add_src1=05, add_src2=03; rs_busy=000 afterwards.
- Issue qj=4 (pending MUL), vk=8'h10; two cycles later cdb_valid, cdb_tag=4, cdb_data=8'h22 → add_start the cycle after capture+1 with add_src1=22, add_src2=10.
- Issue qj=4 in the same cycle as cdb_tag=4, cdb_data=8'h7F → bypass captured; add_start next cycle with add_src1=7F.
- Fill three ready slots (tags 1, 2, 3) while in_flight=1, so issue_ready=0; pulse add_done three times → dispatches in order tags 1, 2, 3, each add_start one cycle after its add_done.
- Slot 0 waiting on tag 5, slot 1 ready, then tag 5 broadcast → slot 1 (tag 2) dispatches first, then tag 1 after add_done; this shows oldest-ready ordering and no blocking on an unready older slot.
- Assert flush with 2 busy slots and in_flight=1, plus issue_valid → rs_busy=000, no add_start, issue dropped, a later stray add_done ignored; assert rst asynchronously mid-dispatch → outputs 0 immediately.
